// File: rtl/game_tick_sched_pkg.sv
// Shared state encodings, default timing constants and the step-period helper
// for the snake game-speed scheduler.
package game_tick_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    localparam int BASE_MS_DEF   = 200;
    localparam int STEP_MS_DEF   = 20;
    localparam int MIN_MS_DEF    = 40;
    localparam int MAX_LEVEL_DEF = 15;
    localparam int PW_DEF        = 10;

    // Signed int math so a high level clamps to the floor instead of wrapping.
    function automatic int calc_period(input int base_ms, input int step_ms,
                                       input int min_ms, input int lvl);
        int p;
        p = base_ms - lvl * step_ms;
        return (p < min_ms) ? min_ms : p;
    endfunction

endpackage

// File: rtl/game_tick_sched_ms_period_cnt.sv
// Millisecond counter: counts enabled ticks and pulses done (combinationally)
// on the tick that completes the current period, then restarts from zero.
module ms_period_cnt #(
    parameter int PW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          enable,
    input  logic          clear,
    input  logic [PW-1:0] period,
    output logic [PW-1:0] ms_cnt,
    output logic          done
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          wrap;

    // ">=" lets a shortened period fire on the next tick when the count is already past it.
    assign wrap = (cnt_q >= (period - PW'(1)));

    always_comb begin
        cnt_d = cnt_q;
        done  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && tick) begin
            if (wrap) begin
                cnt_d = '0;
                done  = 1'b1;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign ms_cnt = cnt_q;

endmodule

// File: rtl/game_tick_sched.sv
// Game-speed scheduler: phase FSM, speed level and registered step period;
// emits a one-cycle step strobe every period_ms milliseconds while running.
module game_tick_sched
    import game_tick_sched_pkg::*;
#(
    parameter int BASE_MS   = BASE_MS_DEF,
    parameter int STEP_MS   = STEP_MS_DEF,
    parameter int MIN_MS    = MIN_MS_DEF,
    parameter int MAX_LEVEL = MAX_LEVEL_DEF,
    parameter int PW        = PW_DEF
) (
    input  logic          mclk,
    input  logic          clr_n,
    input  logic          tick_1ms,
    input  logic          start,
    input  logic          pause_tog,
    input  logic          speed_up,
    input  logic          game_over,
    output logic          step,
    output logic [1:0]    state,
    output logic [3:0]    level,
    output logic [PW-1:0] period_ms
);

    state_e        state_q, state_d;
    logic [3:0]    level_q, level_d;
    logic [PW-1:0] period_q, period_d;
    logic          step_q, step_d;

    logic          cnt_en, cnt_clr, lvl_clr, lvl_inc;
    logic [PW-1:0] ms_cnt;
    logic          cnt_done;

    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // game_over outranks pause_tog; start only matters in IDLE/OVER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (game_over) state_d = ST_OVER;
                      else if (pause_tog) state_d = ST_PAUSE;
            ST_PAUSE: if (game_over) state_d = ST_OVER;
                      else if (pause_tog) state_d = ST_RUN;
            ST_OVER:  if (start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counting only while staying in RUN: a transition on a completing tick
    // suppresses the step and freezes the pre-tick count.
    always_comb begin
        cnt_en  = (state_q == ST_RUN) && (state_d == ST_RUN);
        cnt_clr = (state_q == ST_IDLE) && (state_d == ST_RUN);
        lvl_clr = cnt_clr;
        lvl_inc = (state_q == ST_RUN) && speed_up;
    end

    ms_period_cnt #(.PW(PW)) u_cnt (
        .clk    (mclk),
        .rst_n  (clr_n),
        .tick   (tick_1ms),
        .enable (cnt_en),
        .clear  (cnt_clr),
        .period (period_q),
        .ms_cnt (ms_cnt),
        .done   (cnt_done)
    );

    always_comb begin
        level_d = level_q;
        if (lvl_clr)
            level_d = 4'd0;
        else if (lvl_inc && (level_q < 4'(MAX_LEVEL)))
            level_d = level_q + 4'd1;
    end

    // Derived from the registered level, so the period lags a level change by one cycle.
    always_comb begin
        period_d = PW'(calc_period(BASE_MS, STEP_MS, MIN_MS, int'(level_q)));
        step_d   = cnt_done;
    end

    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            level_q  <= 4'd0;
            period_q <= PW'(BASE_MS);
            step_q   <= 1'b0;
        end else begin
            level_q  <= level_d;
            period_q <= period_d;
            step_q   <= step_d;
        end
    end

    // The count wraps at period-1 and periods only shrink from BASE_MS.
    a_cnt_range: assert property (@(posedge mclk) disable iff (!clr_n)
        ms_cnt < PW'(BASE_MS));

    assign step      = step_q;
    assign state     = state_q;
    assign level     = level_q;
    assign period_ms = period_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed bench for game_tick_sched with a cycle-level reference model and
// literal checkpoints for the key scenarios.
module tb_game_tick_sched;

    logic       mclk = 1'b0;
    logic       clr_n = 1'b0;
    logic       tick_1ms = 1'b0, start = 1'b0, pause_tog = 1'b0;
    logic       speed_up = 1'b0, game_over = 1'b0;
    logic       step;
    logic [1:0] state;
    logic [3:0] level;
    logic [9:0] period_ms;

    int n_chk = 0, n_fail = 0;
    int tick_cnt = 0, steps = 0, last_step_tick = 0;
    int step_at[3];

    // Reference model state
    int m_state = 0, m_level = 0, m_cnt = 0, m_step = 0, m_period = 200;
    int m_nxt, m_lvl0;

    localparam logic [4:0] T = 5'b10000, S = 5'b01000, P = 5'b00100,
                           U = 5'b00010, G = 5'b00001;

    always #5 mclk = ~mclk;

    game_tick_sched dut (
        .mclk(mclk), .clr_n(clr_n), .tick_1ms(tick_1ms), .start(start),
        .pause_tog(pause_tog), .speed_up(speed_up), .game_over(game_over),
        .step(step), .state(state), .level(level), .period_ms(period_ms)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            m_state = 0; m_level = 0; m_cnt = 0; m_step = 0; m_period = 200;
        end else begin
            m_nxt  = m_state;
            m_lvl0 = m_level;
            m_step = 0;
            case (m_state)
                0: if (start) m_nxt = 1;
                1: if (game_over) m_nxt = 3; else if (pause_tog) m_nxt = 2;
                2: if (game_over) m_nxt = 3; else if (pause_tog) m_nxt = 1;
                default: if (start) m_nxt = 0;
            endcase
            if (m_state == 1 && m_nxt == 1 && tick_1ms) begin
                if (m_cnt >= m_period - 1) begin m_cnt = 0; m_step = 1; end
                else m_cnt = m_cnt + 1;
            end
            if (m_state == 1 && speed_up && m_level < 15) m_level = m_level + 1;
            if (m_state == 0 && m_nxt == 1) begin m_cnt = 0; m_level = 0; end
            m_period = (200 - m_lvl0 * 20 < 40) ? 40 : 200 - m_lvl0 * 20;
            m_state  = m_nxt;
        end
    end

    always @(negedge mclk) begin
        chk("step", int'(step), m_step);
        chk("state", int'(state), m_state);
        chk("level", int'(level), m_level);
        chk("period_ms", int'(period_ms), m_period);
        if (step === 1'b1) begin
            steps++;
            last_step_tick = tick_cnt;
            if (steps <= 3) step_at[steps-1] = tick_cnt;
        end
    end

    task automatic cyc(input logic [4:0] v);
        @(posedge mclk); #1;
        {tick_1ms, start, pause_tog, speed_up, game_over} = v;
        @(posedge mclk); #1;
        {tick_1ms, start, pause_tog, speed_up, game_over} = 5'b0;
        if (v[4]) tick_cnt++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) cyc(T);
    endtask

    task automatic settle();
        @(negedge mclk); #1;
    endtask

    int s0;

    initial begin
        repeat (3) @(posedge mclk);
        #1 clr_n = 1'b1;
        settle();
        chk("rst_state", int'(state), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_period", int'(period_ms), 200);
        chk("rst_step", int'(step), 0);

        // 1: 600 ticks -> steps after ticks 200/400/600
        cyc(S);
        tick_n(600);
        settle();
        chk("t1_steps", steps, 3);
        chk("t1_step0", step_at[0], 200);
        chk("t1_step1", step_at[1], 400);
        chk("t1_step2", step_at[2], 600);
        chk("t1_state", int'(state), 1);

        // 2: level ramp and saturation
        for (int i = 1; i <= 16; i++) begin
            cyc(U);
            @(posedge mclk); #1;
            chk("t2_level", int'(level), (i > 15) ? 15 : i);
            if (i == 1)  chk("t2_p1", int'(period_ms), 180);
            if (i == 8)  chk("t2_p8", int'(period_ms), 40);
            if (i == 12) chk("t2_p12", int'(period_ms), 40);
        end

        // 5: game_over beats pause_tog, then two starts to run again
        s0 = steps;
        cyc(G | P);
        settle();
        chk("t5_over", int'(state), 3);
        chk("t5_nostep", steps, s0);
        cyc(S);
        chk("t5_idle", int'(state), 0);
        cyc(S);
        @(posedge mclk); #1;
        chk("t5_run", int'(state), 1);
        chk("t5_level", int'(level), 0);
        chk("t5_period", int'(period_ms), 200);

        // 3: shortened period with count already past it
        s0 = steps;
        tick_n(150);
        settle();
        chk("t3_nostep", steps, s0);
        repeat (4) cyc(U);
        @(posedge mclk); #1;
        chk("t3_period", int'(period_ms), 120);
        cyc(T);
        settle();
        chk("t3_step", steps, s0 + 1);
        chk("t3_step_tick", last_step_tick, tick_cnt);
        tick_n(119);
        settle();
        chk("t3_cnt0_a", steps, s0 + 1);
        tick_n(1);
        settle();
        chk("t3_cnt0_b", steps, s0 + 2);

        // 4: pause holds the count
        cyc(G); cyc(S); cyc(S);
        @(posedge mclk); #1;
        chk("t4_period", int'(period_ms), 200);
        s0 = steps;
        tick_n(100);
        cyc(P);
        tick_n(500);
        settle();
        chk("t4_paused", int'(state), 2);
        chk("t4_nostep", steps, s0);
        cyc(P);
        tick_n(99);
        settle();
        chk("t4_resume_a", steps, s0);
        tick_n(1);
        settle();
        chk("t4_resume_b", steps, s0 + 1);
        chk("t4_run", int'(state), 1);
        tick_n(199);
        cyc(T | P);
        settle();
        chk("t4_pause_on_tick", steps, s0 + 1);
        chk("t4_pause_state", int'(state), 2);
        cyc(P);
        cyc(T);
        settle();
        chk("t4_held_cnt", steps, s0 + 2);

        // 6: async reset with a step in flight
        tick_n(185);
        cyc(U);
        @(posedge mclk); #1;
        chk("t6_level1", int'(level), 1);
        @(posedge mclk); #1 tick_1ms = 1'b1;
        @(posedge mclk); #1 tick_1ms = 1'b0;
        tick_cnt++;
        chk("t6_inflight", int'(step), 1);
        clr_n = 1'b0;
        #3;
        chk("t6_state", int'(state), 0);
        chk("t6_level", int'(level), 0);
        chk("t6_step", int'(step), 0);
        chk("t6_period", int'(period_ms), 200);
        clr_n = 1'b1;

        repeat (4) settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
